// File: rtl/sw_debounce_sync_if.sv
// rtl/sw_debounce_sync_if.sv - raw switch input and debounced output bundle
// master drives the raw switches, slave is the debouncer.
interface sw_debounce_sync_if #(
   parameter int N = 16
);
   logic [N-1:0] sw_raw;
   logic [N-1:0] sw_db;
   logic         sw_chg;
   logic [N-1:0] sw_rise;
   logic [N-1:0] sw_fall;

   modport master (
      output sw_raw,
      input  sw_db,
      input  sw_chg,
      input  sw_rise,
      input  sw_fall
   );

   modport slave (
      input  sw_raw,
      output sw_db,
      output sw_chg,
      output sw_rise,
      output sw_fall
   );
endinterface

// File: rtl/sw_debounce_sync.sv
// rtl/sw_debounce_sync.sv - two-flop sync plus per-bit tick-based debouncer for slide switches
// Optional SW_DB_EDGE_EN builds registered per-bit rise/fall strobes; otherwise they read 0.
module sw_debounce_sync #(
   parameter int N          = 16,
   parameter int TICK_DIV   = 100000,
   parameter int STABLE_CNT = 8
) (
   input logic               Clk_100M,
   input logic               reset,
   sw_debounce_sync_if.slave sw_if
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = $clog2(STABLE_CNT + 1);

   logic [PW-1:0] r_presc;
   logic [N-1:0]  r_sw_s1;
   logic [N-1:0]  r_sw_s2;
   logic [N-1:0]  r_sw_db;
   logic          r_sw_chg;
   logic [CW-1:0] r_cnt [N];

   logic          w_tick;
   logic [N-1:0]  w_db_nxt;
   logic [CW-1:0] w_cnt_nxt [N];

   assign w_tick = (r_presc == PW'(TICK_DIV - 1));

   // A bit only advances while it disagrees; agreeing for one cycle restarts its count.
   always_comb begin
      w_db_nxt = r_sw_db;
      for (int i = 0; i < N; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (r_sw_s2[i] == r_sw_db[i]) begin
            w_cnt_nxt[i] = '0;
         end else if (w_tick) begin
            if (r_cnt[i] == CW'(STABLE_CNT - 1)) begin
               w_db_nxt[i]  = r_sw_s2[i];
               w_cnt_nxt[i] = '0;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge Clk_100M or negedge reset) begin
      if (!reset) begin
         r_presc  <= '0;
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
         r_sw_db  <= '0;
         r_sw_chg <= 1'b0;
         for (int i = 0; i < N; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_presc  <= w_tick ? '0 : r_presc + PW'(1);
         r_sw_s1  <= sw_if.sw_raw;
         r_sw_s2  <= r_sw_s1;
         r_sw_db  <= w_db_nxt;
         r_sw_chg <= |(w_db_nxt ^ r_sw_db);
         for (int i = 0; i < N; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

   assign sw_if.sw_db  = r_sw_db;
   assign sw_if.sw_chg = r_sw_chg;

`ifdef SW_DB_EDGE_EN
   logic [N-1:0] r_sw_rise;
   logic [N-1:0] r_sw_fall;

   always_ff @(posedge Clk_100M or negedge reset) begin
      if (!reset) begin
         r_sw_rise <= '0;
         r_sw_fall <= '0;
      end else begin
         r_sw_rise <= w_db_nxt & ~r_sw_db;
         r_sw_fall <= ~w_db_nxt & r_sw_db;
      end
   end

   assign sw_if.sw_rise = r_sw_rise;
   assign sw_if.sw_fall = r_sw_fall;
`else
   assign sw_if.sw_rise = '0;
   assign sw_if.sw_fall = '0;
`endif
endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb/tb_sw_debounce_sync.sv - randomized and directed bench for sw_debounce_sync
// Reference model counts ticks arithmetically over each disagreement interval.
module tb_sw_debounce_sync;
   localparam int N = 16;
   localparam int T = 4;
   localparam int S = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   sw_debounce_sync_if #(.N(N)) sw_if ();

   sw_debounce_sync #(.N(N), .TICK_DIV(T), .STABLE_CNT(S)) dut (
      .Clk_100M (clk),
      .reset    (rst_n),
      .sw_if    (sw_if)
   );

   always #5 clk = ~clk;

   // model state: k = edges since reset release, hist[k] = raw value sampled at edge k
   int          k;
   logic [N-1:0] hist [$];
   int          run_start [N];
   logic [N-1:0] m_db, m_rise, m_fall;
   logic        m_chg;

   function automatic int ticks_in(input int a, input int b);
      return (b + 1) / T - a / T;
   endfunction

   task automatic model_clear();
      k = 0;
      hist.delete();
      for (int i = 0; i < N; i++) run_start[i] = -1;
      m_db = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
   endtask

   initial model_clear();

   always @(posedge clk) begin
      if (rst_n) begin
         logic [N-1:0] s2, old;
         s2  = (k >= 2) ? hist[k-2] : '0;
         old = m_db;
         hist.push_back(sw_if.sw_raw);
         for (int i = 0; i < N; i++) begin
            if (s2[i] == old[i]) begin
               run_start[i] = -1;
            end else begin
               if (run_start[i] < 0) run_start[i] = k;
               if ((k % T == T - 1) && ticks_in(run_start[i], k) == S) begin
                  m_db[i] = s2[i];
                  run_start[i] = -1;
               end
            end
         end
         m_chg  = (m_db != old);
`ifdef SW_DB_EDGE_EN
         m_rise = m_db & ~old;
         m_fall = ~m_db & old;
`else
         m_rise = '0;
         m_fall = '0;
`endif
         k++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_range(input string nm, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   always @(negedge clk) begin
      chk("db", 32'(sw_if.sw_db), 32'(m_db));
      chk("chg", 32'(sw_if.sw_chg), 32'(m_chg));
      chk("rise", 32'(sw_if.sw_rise), 32'(m_rise));
      chk("fall", 32'(sw_if.sw_fall), 32'(m_fall));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      model_clear();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_db(input logic [N-1:0] exp, input int lo, input int hi, input string nm);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (sw_if.sw_db !== exp && n < 40);
      chk_range({nm, "_latency"}, n, lo, hi);
      chk({nm, "_chg_pulse"}, 32'(sw_if.sw_chg), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int chg_seen;
      logic [N-1:0] v;
      sw_if.sw_raw = '0;
      #2;

      // 1: held in reset with all switches on
      sw_if.sw_raw = 16'hFFFF;
      chg_seen = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (sw_if.sw_db !== 16'h0000 || sw_if.sw_chg !== 1'b0) chg_seen++;
      end
      chk("t1_reset_quiet", 32'(chg_seen), 32'd0);
      rst_n = 1'b1;
      wait_db(16'hFFFF, 12, 12, "t1");

      // 2: single bit rise with random prescaler phase
      sw_if.sw_raw = '0;
      pulse_reset();
      repeat ($urandom_range(0, 3)) step();
      sw_if.sw_raw = 16'h0001;
      wait_db(16'h0001, 11, 14, "t2");
`ifdef SW_DB_EDGE_EN
      chk("t2_rise", 32'(sw_if.sw_rise), 32'h0001);
`else
      chk("t2_rise", 32'(sw_if.sw_rise), 32'h0000);
`endif
      step();
      chk("t2_chg_off", 32'(sw_if.sw_chg), 32'd0);

      // 3: bouncing bit never accepted
      sw_if.sw_raw = '0;
      pulse_reset();
      chg_seen = 0;
      for (int i = 0; i < 60; i++) begin
         if (i % 5 == 0) sw_if.sw_raw[3] = ~sw_if.sw_raw[3];
         step();
         if (sw_if.sw_chg === 1'b1) chg_seen++;
      end
      repeat (5) step();
      chk("t3_no_chg", 32'(chg_seen), 32'd0);
      chk("t3_db", 32'(sw_if.sw_db), 32'h0000);

      // 4: multi-bit accept in one cycle, then release
      sw_if.sw_raw = '0;
      pulse_reset();
      repeat ($urandom_range(0, 3)) step();
      sw_if.sw_raw = 16'hA5A5;
      wait_db(16'hA5A5, 11, 14, "t4_on");
`ifdef SW_DB_EDGE_EN
      chk("t4_rise", 32'(sw_if.sw_rise), 32'hA5A5);
`else
      chk("t4_rise", 32'(sw_if.sw_rise), 32'h0000);
`endif
      step();
      chk("t4_chg_off", 32'(sw_if.sw_chg), 32'd0);
      sw_if.sw_raw = '0;
      wait_db(16'h0000, 11, 14, "t4_off");
`ifdef SW_DB_EDGE_EN
      chk("t4_fall", 32'(sw_if.sw_fall), 32'hA5A5);
`else
      chk("t4_fall", 32'(sw_if.sw_fall), 32'h0000);
`endif

      // 5: reset mid-count discards progress
      sw_if.sw_raw = '0;
      pulse_reset();
      sw_if.sw_raw[7] = 1'b1;
      repeat (9) step();
      chk("t5_before_reset", 32'(sw_if.sw_db), 32'h0000);
      pulse_reset();
      chk("t5_after_reset", 32'(sw_if.sw_db), 32'h0000);
      wait_db(16'h0080, 12, 12, "t5");

      // random segments checked cycle by cycle against the model
      for (int seg = 0; seg < 250; seg++) begin
         int hold;
         v = sw_if.sw_raw ^ 16'($urandom());
         if ($urandom_range(0, 1) == 0) v = sw_if.sw_raw ^ (16'h1 << $urandom_range(0, 15));
         sw_if.sw_raw = v;
         hold = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(1, 6);
         repeat (hold) step();
         if ($urandom_range(0, 29) == 0) pulse_reset();
      end

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
